// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding and default datapath width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned SEL_W         = 3;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// Combinational ALU datapath: unsigned arithmetic, bitwise logic and 1-bit shifts.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c
);

    // One extra bit catches the add carry and, for subtraction, the unsigned borrow.
    logic [WIDTH:0] sum_c;
    logic [WIDTH:0] diff_c;

    assign sum_c  = {1'b0, a} + {1'b0, b};
    assign diff_c = {1'b0, a} - {1'b0, b};

    always_comb begin
        result_c = '0;
        carry_c  = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD: begin
                result_c = sum_c[WIDTH-1:0];
                carry_c  = sum_c[WIDTH];
            end
            OP_SUB: begin
                result_c = diff_c[WIDTH-1:0];
                carry_c  = diff_c[WIDTH];
            end
            OP_AND: result_c = a & b;
            OP_OR:  result_c = a | b;
            OP_XOR: result_c = a ^ b;
            OP_NOT: result_c = ~a;
            OP_SHL: begin
                result_c = {a[WIDTH-2:0], 1'b0};
                carry_c  = a[WIDTH-1];
            end
            OP_SHR: begin
                result_c = {1'b0, a[WIDTH-1:1]};
                carry_c  = a[0];
            end
            default: begin
                result_c = '0;
                carry_c  = 1'b0;
            end
        endcase
    end

endmodule : alu_comb

// File: rtl/alu.sv
// Registered ALU: one result per valid input cycle, latency one clock.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             out_valid
);

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;
    logic [WIDTH-1:0] result_c;
    logic             carry_c;
    logic [WIDTH-1:0] out_d, out_q;
    logic             c_out_d, c_out_q;
    logic             out_valid_d, out_valid_q;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu_comb (
        .a        (a),
        .b        (b),
        .sel      (sel),
        .result_c (result_c),
        .carry_c  (carry_c)
    );

    // Capture on valid, otherwise hold the last result.
    always_comb begin
        out_d       = out_q;
        c_out_d     = c_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d   = result_c;
            c_out_d = carry_c;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            out_q       <= '0;
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign c_out     = c_out_q;
    assign out_valid = out_valid_q;

endmodule : alu

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results queued at drive time, popped on out_valid.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic         in_valid;
    logic [W-1:0] out;
    logic         c_out;
    logic         out_valid;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   last_exp;
    logic [W:0]   cur;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {carry, result}
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] s);
        int unsigned xi, yi;
        xi = int'(x);
        yi = int'(y);
        case (s)
            3'd0: model = (W+1)'(xi + yi);
            3'd1: model = {(xi < yi) ? 1'b1 : 1'b0, W'((xi + 256 - yi) % 256)};
            3'd2: model = {1'b0, x & y};
            3'd3: model = {1'b0, x | y};
            3'd4: model = {1'b0, x ^ y};
            3'd5: model = {1'b0, W'(255 - xi)};
            3'd6: model = {x[W-1], W'((xi * 2) % 256)};
            default: model = {x[0], W'(xi / 2)};
        endcase
    endfunction

    // Drive one cycle; with v=1 the expected value exp_v is queued, then output is checked.
    task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] ts,
                        input logic v, input logic [W:0] exp_v);
        a        = ta;
        b        = tb;
        sel      = ts;
        in_valid = v;
        if (v) exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(v));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(1), 32'(0));
            end else begin
                cur = exp_q.pop_front();
                last_exp = cur;
                check("out", 32'(out), 32'(cur[W-1:0]));
                check("c_out", 32'(c_out), 32'(cur[W]));
            end
        end else begin
            check("hold_out", 32'(out), 32'(last_exp[W-1:0]));
            check("hold_c_out", 32'(c_out), 32'(last_exp[W]));
        end
    endtask

    logic [W:0] sweep_tab [8];
    int         nvalid;
    logic [W-1:0] ra, rb;
    logic [2:0]   rs;

    initial begin
        sweep_tab[0] = 9'h009; sweep_tab[1] = 9'h1FF; sweep_tab[2] = 9'h004; sweep_tab[3] = 9'h005;
        sweep_tab[4] = 9'h001; sweep_tab[5] = 9'h0FB; sweep_tab[6] = 9'h008; sweep_tab[7] = 9'h002;
        last_exp = '0;
        rst_n    = 1'b0;
        a = '0; b = '0; sel = '0; in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'(out), 32'(0));
        check("rst_c_out", 32'(c_out), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step('0, '0, 3'd0, 1'b0, '0);

        // Opcode sweep with fixed operands
        for (int i = 0; i < 8; i++) step(8'h04, 8'h05, 3'(i), 1'b1, sweep_tab[i]);

        step(8'hFF, 8'h01, 3'(OP_ADD), 1'b1, 9'h100);
        step(8'h05, 8'h05, 3'(OP_SUB), 1'b1, 9'h000);
        step(8'h80, 8'h00, 3'(OP_SHL), 1'b1, 9'h100);
        step(8'h01, 8'h00, 3'(OP_SHR), 1'b1, 9'h100);

        // Hold behaviour across idle cycles
        step(8'h3C, 8'h0F, 3'(OP_XOR), 1'b1, 9'h033);
        repeat (3) step(8'hAA, 8'h55, 3'(OP_ADD), 1'b0, '0);

        // Asynchronous reset between edges while out=FB
        step(8'h04, 8'h05, 3'(OP_NOT), 1'b1, 9'h0FB);
        check("pre_rst_out", 32'(out), 32'h0FB);
        #2;
        a = 8'h10; b = 8'h20; sel = 3'(OP_ADD); in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'(0));
        check("async_rst_c_out", 32'(c_out), 32'(0));
        check("async_rst_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("rst_held_valid", 32'(out_valid), 32'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'(0));
        repeat (4) step('0, '0, 3'd0, 1'b0, '0);

        // Randomized run against the reference model
        nvalid = 0;
        while (nvalid < 1000) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 3'($urandom);
            if ($urandom_range(3) == 0) begin
                step(ra, rb, rs, 1'b0, '0);
            end else begin
                step(ra, rb, rs, 1'b1, model(ra, rb, rs));
                nvalid++;
            end
        end
        step('0, '0, 3'd0, 1'b0, '0);
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu
